uart_tx_buffered: RTL and testbench

//  Byte-buffered 8N1 UART transmitter: the serial output stage that drives uart_tx_o of uart_trng.

---
 rtl/uart_tx_buffered.sv | 136 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Byte-buffered UART transmitter: valid/ready input, small FIFO, back-to-back 8N1 frames.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQ   = 10_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W        = PTR_W + 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [LVL_W-1:0] level_next;
  logic             bit_end;
  logic             push;
  logic             pop;
  logic             tx_next;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  // ready_o is a registered flag that mirrors !full of the registered level
  assign push    = valid_i && ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next state, FIFO pop request and next line value; tx_o trails state by one cycle.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_next    = 1'b1;
    level_next = level_o;
    case (state)
      IDLE: begin
        if (level_o != '0) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_next = data_q[bit_idx];
        if (bit_end && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = ^data_q;
        if (bit_end) state_next = STOP;
      end
`endif
      STOP: begin
        tx_next = 1'b1;
        if (bit_end) begin
          if (level_o != '0) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (push && !pop)      level_next = level_o + LVL_W'(1);
    else if (pop && !push) level_next = level_o - LVL_W'(1);
  end

  // Datapath: FIFO bookkeeping, baud timing, output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      bit_idx <= '0;
      data_q  <= '0;
      wptr    <= '0;
      rptr    <= '0;
      level_o <= '0;
      ready_o <= 1'b1;
      tx_o    <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      tx_o    <= tx_next;
      busy_o  <= (state != IDLE) || (level_o != '0);
      level_o <= level_next;
      ready_o <= (level_next != LVL_W'(FIFO_DEPTH));
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop) begin
        rptr   <= rptr + PTR_W'(1);
        data_q <= mem[rptr];
      end
      if ((state == IDLE) || bit_end) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);
      if ((state == DATA) && bit_end) bit_idx <= bit_idx + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= data_i;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: a line monitor decodes frames and compares them
// against bytes queued at each handshake; a second 9600-baud instance gets a smoke frame.
module tb_uart_tx_buffered;

  localparam int unsigned CPB  = 10;
  localparam int unsigned CPBS = 10_000_000 / 9600;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [7:0] data_s = 8'h00;
  logic       valid = 1'b0;
  logic       valid_s = 1'b0;
  logic       ready, tx, busy, ready_s, tx_s, busy_s;
  logic [2:0] level, level_s;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       mon_en = 1'b1;
  logic       has_prev = 1'b0;
  logic       saw_full = 1'b0;
  int         prev_end = 0;
  int         max_gap = 0;

  uart_tx_buffered #(.CLK_FREQ(10_000_000), .BAUD(1_000_000), .FIFO_DEPTH(4)) u_dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(ready), .tx_o(tx), .busy_o(busy), .level_o(level)
  );

  uart_tx_buffered #(.CLK_FREQ(10_000_000), .BAUD(9600), .FIFO_DEPTH(4)) u_slow (
    .clk_i(clk), .rst_i(rst), .data_i(data_s), .valid_i(valid_s),
    .ready_o(ready_s), .tx_o(tx_s), .busy_o(busy_s), .level_o(level_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Call at a negedge; returns at the negedge after the handshake edge with n = that edge's cycle.
  task automatic push(input logic [7:0] b, input bit track, output int n);
    int t;
    t = 0;
    data  = b;
    valid = 1'b1;
    check("ready_vs_level", 32'(ready), 32'(level != 3'd4));
    while (!ready && t < 5000) begin
      if (level == 3'd4) saw_full = 1'b1;
      @(negedge clk);
      check("ready_vs_level", 32'(ready), 32'(level != 3'd4));
      t++;
    end
    check("push_accept", 32'(ready), 32'd1);
    if (track) exp_q.push_back(b);
    @(negedge clk);
    valid = 1'b0;
    n = cyc;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((busy || exp_q.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(busy || (exp_q.size() != 0)), 32'd0);
  endtask

  // Line monitor: every bit must hold for exactly CPB samples; decoded byte checked against scoreboard.
  initial begin
    logic             prev_tx;
    logic             v, stable;
    logic [NBITS-1:0] bits;
    logic [7:0]       e;
    int               gap;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev_tx === 1'b1 && tx === 1'b0) begin
        if (has_prev) begin
          gap = cyc - prev_end - 1;
          if (gap > max_gap) max_gap = gap;
        end
        for (int b = 0; b < NBITS; b++) begin
          if (b != 0) @(negedge clk);
          v = tx;
          stable = 1'b1;
          for (int k = 1; k < int'(CPB); k++) begin
            @(negedge clk);
            if (tx !== v) stable = 1'b0;
          end
          bits[b] = v;
          check("bit_len", 32'(stable), 32'd1);
        end
        prev_end = cyc;
        has_prev = 1'b1;
        check("start_bit", 32'(bits[0]), 32'd0);
        check("stop_bit", 32'(bits[NBITS-1]), 32'd1);
        if (exp_q.size() == 0) begin
          check("sb_unexpected_frame", 32'(bits[8:1]), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("byte", 32'(bits[8:1]), 32'(e));
`ifdef UART_TX_PARITY_EN
          check("parity", 32'(bits[9]), 32'(^e));
`endif
        end
      end
      prev_tx = tx;
    end
  end

  initial begin
    int         n, lows, t;
    logic [7:0] sb;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // single byte from idle: latency and busy tail
    push(8'hA5, 1'b1, n);
    check("t1_level_after_push", 32'(level), 32'd1);
    @(negedge clk);
    check("t1_tx_idle_n1", 32'(tx), 32'd1);
    check("t1_level_popped", 32'(level), 32'd0);
    @(negedge clk);
    check("t1_tx_start_n2", 32'(tx), 32'd0);
    while (cyc < n + 101) @(negedge clk);
    check("t1_busy_last_stop", 32'(busy), 32'd1);
    check("t1_tx_last_stop", 32'(tx), 32'd1);
    @(negedge clk);
    check("t1_busy_fall", 32'(busy), 32'd0);
    wait_idle(500);

    // fast burst of 8: full back-pressure, no gap between frames
    has_prev = 1'b0;
    max_gap  = 0;
    saw_full = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(i), 1'b1, n);
    wait_idle(3000);
    check("t2_b2b_gap", 32'(max_gap), 32'd0);
    check("t2_saw_full", 32'(saw_full), 32'd1);

    // reset in the middle of data bit 3
    mon_en = 1'b0;
    push(8'h3C, 1'b0, n);
    @(negedge clk);
    @(negedge clk);
    check("t3_frame_started", 32'(tx), 32'd0);
    while (cyc < n + 46) @(negedge clk);
    check("t3_bit3_value", 32'(tx), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t3_tx_after_rst", 32'(tx), 32'd1);
    check("t3_level_after_rst", 32'(level), 32'd0);
    check("t3_busy_after_rst", 32'(busy), 32'd0);
    check("t3_ready_after_rst", 32'(ready), 32'd1);
    lows = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t3_no_falling_edge", 32'(lows), 32'd0);
    check("t3_busy_stays_low", 32'(busy), 32'd0);
    mon_en = 1'b1;

    // data changed while stalled must never reach the line
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), 1'b1, n);
    check("t4_full_level", 32'(level), 32'd4);
    check("t4_full_ready", 32'(ready), 32'd0);
    data  = 8'hEE;
    valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_ready", 32'(ready), 32'd0);
    end
    push(8'h45, 1'b1, n);
    wait_idle(2000);

    // pointer wrap: 9 bytes in bursts of 4, 4, 1
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b1, n);
    wait_idle(2000);
    for (int i = 4; i < 8; i++) push(8'h10 + 8'(i), 1'b1, n);
    wait_idle(2000);
    push(8'h18, 1'b1, n);
    wait_idle(2000);

`ifdef UART_TX_PARITY_EN
    // 8E1 frames back to back, 11 bits of CPB cycles each
    has_prev = 1'b0;
    max_gap  = 0;
    push(8'h07, 1'b1, n);
    push(8'h03, 1'b1, n);
    wait_idle(1000);
    check("t6_b2b_gap", 32'(max_gap), 32'd0);
`endif

    // 9600-baud smoke frame sampled at bit centres
    sb = 8'h5A;
    check("slow_ready", 32'(ready_s), 32'd1);
    data_s  = sb;
    valid_s = 1'b1;
    @(negedge clk);
    valid_s = 1'b0;
    t = 0;
    while (tx_s && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("slow_start_seen", 32'(tx_s), 32'd0);
    repeat (CPBS / 2) @(negedge clk);
    check("slow_start_mid", 32'(tx_s), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPBS) @(negedge clk);
      check("slow_bit", 32'(tx_s), 32'(sb[i]));
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPBS) @(negedge clk);
    check("slow_parity", 32'(tx_s), 32'(^sb));
`endif
    repeat (CPBS) @(negedge clk);
    check("slow_stop", 32'(tx_s), 32'd1);
    check("slow_busy_in_stop", 32'(busy_s), 32'd1);
    repeat (CPBS) @(negedge clk);
    check("slow_busy_done", 32'(busy_s), 32'd0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
